// File: rtl/round_robin_rotating_arbiter.sv
// round_robin_rotating_arbiter: rotate-encode-rotate round-robin arbiter with a
// valid/ready grant handshake that locks a stalled grant until it is accepted.
module round_robin_rotating_arbiter #(
    parameter int SIZE = 8,
    localparam int INDEX_WIDTH = $clog2(SIZE)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [SIZE-1:0]        requests,
    output logic [SIZE-1:0]        grant,
    output logic [INDEX_WIDTH-1:0] grant_index,
    output logic                   grant_valid,
    input  logic                   grant_ready,
    output logic [INDEX_WIDTH-1:0] priority_pointer
);
    localparam logic [INDEX_WIDTH:0]   SIZE_W = (INDEX_WIDTH+1)'(SIZE);
    localparam logic [INDEX_WIDTH-1:0] LAST   = INDEX_WIDTH'(SIZE-1);
    logic [INDEX_WIDTH-1:0] pointer, locked_index, first, arb_index;
    logic                   locked, lock_active;
    logic [2*SIZE-1:0]      right_dbl, left_dbl;
    logic [SIZE-1:0]        rotated, first_oh, arb_grant, lock_grant;
    logic [INDEX_WIDTH:0]   index_sum;
    assign right_dbl = {requests, requests} >> pointer;
    assign rotated   = right_dbl[SIZE-1:0];
    assign first_oh  = rotated & (~rotated + SIZE'(1));
    always_comb begin
        first = '0;
        for (int i = SIZE-1; i >= 0; i--)
            if (rotated[i]) first = INDEX_WIDTH'(i);
    end
    assign left_dbl  = {first_oh, first_oh} << pointer;
    assign arb_grant = left_dbl[2*SIZE-1:SIZE];
    assign index_sum = {1'b0, first} + {1'b0, pointer};
    assign arb_index = rotated == '0 ? '0
                     : index_sum >= SIZE_W ? INDEX_WIDTH'(index_sum - SIZE_W)
                     : index_sum[INDEX_WIDTH-1:0];
    // A lock whose requester has dropped is ignored so arbitration recovers
    assign lock_active = locked & requests[locked_index];
    assign lock_grant  = SIZE'(1) << locked_index;
    assign grant            = lock_active ? lock_grant : arb_grant;
    assign grant_index      = lock_active ? locked_index : arb_index;
    assign grant_valid      = lock_active | (|requests);
    assign priority_pointer = pointer;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pointer      <= '0;
            locked       <= 1'b0;
            locked_index <= '0;
        end else if (grant_valid && grant_ready) begin
            pointer <= grant_index == LAST ? '0 : grant_index + 1'b1;
            locked  <= 1'b0;
        end else if (grant_valid) begin
            locked       <= 1'b1;
            locked_index <= grant_index;
        end else begin
            locked <= 1'b0;
        end
    end
endmodule

// File: tb/tb_round_robin_rotating_arbiter.sv
// tb_round_robin_rotating_arbiter: directed scenarios plus random traffic
// against a queue-free round-robin reference model with handshake locking.
module tb_round_robin_rotating_arbiter;
    logic       clock = 0;
    logic       reset = 0;
    logic [7:0] requests = 0;
    logic [7:0] grant;
    logic [2:0] grant_index;
    logic       grant_valid;
    logic       grant_ready = 0;
    logic [2:0] priority_pointer;
    int n_tests = 0;
    int n_fail = 0;
    int m_ptr = 0;
    bit m_locked = 0;
    int m_lidx = 0;
    int e_idx;
    bit e_valid;
    round_robin_rotating_arbiter #(.SIZE(8)) dut (
        .clock(clock),
        .reset(reset),
        .requests(requests),
        .grant(grant),
        .grant_index(grant_index),
        .grant_valid(grant_valid),
        .grant_ready(grant_ready),
        .priority_pointer(priority_pointer)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Search requesters starting at the pointer; a held lock wins if still requested
    task automatic model_expect();
        e_valid = 0;
        e_idx = 0;
        if (m_locked && requests[m_lidx]) begin
            e_valid = 1;
            e_idx = m_lidx;
        end else begin
            for (int k = 0; k < 8; k++)
                if (!e_valid && requests[(m_ptr + k) % 8]) begin
                    e_valid = 1;
                    e_idx = (m_ptr + k) % 8;
                end
        end
    endtask
    task automatic check_outputs(input string tag);
        model_expect();
        check({tag, "_valid"}, 32'(grant_valid), 32'(e_valid));
        check({tag, "_index"}, 32'(grant_index), 32'(e_idx));
        check({tag, "_grant"}, 32'(grant), e_valid ? 32'(1) << e_idx : 32'd0);
        check({tag, "_ptr"}, 32'(priority_pointer), 32'(m_ptr));
        check({tag, "_onehot"}, 32'($countones(grant) <= 1 && grant_valid == (|grant)), 32'd1);
    endtask
    task automatic cycle(input logic [7:0] r, input logic rdy, input string tag);
        requests = r;
        grant_ready = rdy;
        @(negedge clock);
        check_outputs(tag);
        @(posedge clock);
        if (e_valid && rdy) begin
            m_ptr = (e_idx + 1) % 8;
            m_locked = 0;
        end else if (e_valid) begin
            m_locked = 1;
            m_lidx = e_idx;
        end else
            m_locked = 0;
        #1;
    endtask
    task automatic do_reset();
        requests = 0;
        grant_ready = 0;
        reset = 1;
        m_ptr = 0;
        m_locked = 0;
        m_lidx = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 0;
        @(posedge clock);
        #1;
    endtask
    initial begin
        do_reset();
        for (int i = 0; i < 5; i++) cycle(8'h00, 1'b0, "s1_idle");
        for (int i = 0; i < 9; i++) begin
            cycle(8'hFF, 1'b1, "s2_all");
            check("s2_seq", 32'(priority_pointer), 32'((i + 1) % 8));
        end
        do_reset();
        cycle(8'b0000_0100, 1'b1, "s3_set");
        check("s3_ptr3", 32'(priority_pointer), 32'd3);
        requests = 8'b0000_0101;
        #1;
        check("s3_wrap_idx", 32'(grant_index), 32'd0);
        check("s3_wrap_grant", 32'(grant), 32'h01);
        cycle(8'b0000_0101, 1'b1, "s3_wrap");
        check("s3_ptr1", 32'(priority_pointer), 32'd1);
        check("s3_next_idx", 32'(grant_index), 32'd2);
        do_reset();
        cycle(8'b0001_0010, 1'b0, "s4_l1");
        cycle(8'b0001_0011, 1'b0, "s4_l2");
        cycle(8'b0001_0011, 1'b0, "s4_l3");
        check("s4_held_idx", 32'(grant_index), 32'd1);
        check("s4_held_grant", 32'(grant), 32'h02);
        cycle(8'b0001_0011, 1'b1, "s4_acc");
        check("s4_ptr2", 32'(priority_pointer), 32'd2);
        check("s4_next_idx", 32'(grant_index), 32'd4);
        do_reset();
        cycle(8'b0001_0010, 1'b0, "s5_lock");
        requests = 8'b0001_0011;
        @(negedge clock);
        check("s5_locked_idx", 32'(grant_index), 32'd1);
        reset = 1;
        #1;
        check("s5_rst_idx", 32'(grant_index), 32'd0);
        check("s5_rst_grant", 32'(grant), 32'h01);
        check("s5_rst_ptr", 32'(priority_pointer), 32'd0);
        m_ptr = 0;
        m_locked = 0;
        @(posedge clock);
        #1;
        reset = 0;
        cycle(8'b0001_0011, 1'b1, "s5_acc");
        check("s5_ptr1", 32'(priority_pointer), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(8'h80, 1'b1, "s6_bit7");
            check("s6_ptr0", 32'(priority_pointer), 32'd0);
        end
        for (int i = 0; i < 1000; i++)
            cycle(8'($urandom), 1'($urandom_range(0, 1)), "rand");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
